// File: rtl/arch_maptable.sv
// Retirement map table: commits arch->phys mappings from retiring ROB entries and emits told-register frees.
// Zero-cycle latency for recovery_map, frees and recover; the map, told_mismatch and retire_count update at posedge.
// No backpressure: every retiring way is consumed in the cycle it is presented.
module arch_maptable #(
    parameter int WAYS   = 2,
    parameter int N_ARCH = 32,
    parameter int N_PHYS = 64,
    parameter int AR_W   = $clog2(N_ARCH),
    parameter int PR_W   = $clog2(N_PHYS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WAYS-1:0]        rt_valid,
    input  logic [WAYS*AR_W-1:0]   rt_ar_idx,
    input  logic [WAYS*PR_W-1:0]   rt_t_idx,
    input  logic [WAYS*PR_W-1:0]   rt_told_idx,
    input  logic [WAYS-1:0]        rt_mispredict,
    output logic                   br_recover_enable,
    output logic [N_ARCH*PR_W-1:0] recovery_map,
    output logic [WAYS-1:0]        fl_retire_valid,
    output logic [WAYS*PR_W-1:0]   fl_retire_told,
    output logic                   told_mismatch,
    output logic [31:0]            retire_count
);

    logic [PR_W-1:0] map_q [N_ARCH];
    logic [PR_W-1:0] tmp   [N_ARCH];
    logic [WAYS-1:0] commit;
    logic            squash;
    logic            mismatch;
    logic [31:0]     n_commit;
    logic [AR_W-1:0] ar;
    logic [PR_W-1:0] told;

    // Ways up to and including the oldest valid mispredict commit; younger ones are squashed.
    always_comb begin
        commit = '0;
        squash = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            commit[i] = rt_valid[i] & ~squash & ~reset;
            if (rt_valid[i] && rt_mispredict[i]) squash = 1'b1;
        end
    end

    // Oldest-first application so the youngest write to an arch reg wins; told is checked
    // against the mapping as left by all older ways in the same group.
    always_comb begin
        mismatch        = 1'b0;
        n_commit        = '0;
        fl_retire_valid = '0;
        fl_retire_told  = '0;
        ar              = '0;
        told            = '0;
        for (int a = 0; a < N_ARCH; a++) tmp[a] = map_q[a];
        for (int i = 0; i < WAYS; i++) begin
            ar   = rt_ar_idx[i*AR_W +: AR_W];
            told = rt_told_idx[i*PR_W +: PR_W];
            n_commit = n_commit + 32'(commit[i]);
            if (commit[i] && ar != '0) begin
                if (told != tmp[ar]) mismatch = 1'b1;
                tmp[ar] = rt_t_idx[i*PR_W +: PR_W];
                fl_retire_valid[i] = 1'b1;
                fl_retire_told[i*PR_W +: PR_W] = told;
            end
        end
    end

    always_comb begin
        for (int a = 0; a < N_ARCH; a++) recovery_map[a*PR_W +: PR_W] = tmp[a];
    end

    assign br_recover_enable = ~reset & |(rt_valid & rt_mispredict);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < N_ARCH; a++) map_q[a] <= PR_W'(a);
            told_mismatch <= 1'b0;
            retire_count  <= '0;
        end else begin
            for (int a = 0; a < N_ARCH; a++) map_q[a] <= tmp[a];
            if (mismatch) told_mismatch <= 1'b1;
            retire_count <= retire_count + n_commit;
        end
    end

endmodule

// File: tb/tb_arch_maptable.sv
// Directed table-driven bench for arch_maptable, plus reset-with-retires sequence.
module tb_arch_maptable;
    localparam int WAYS = 2, N_ARCH = 32, AR_W = 5, PR_W = 6;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [WAYS-1:0]        rt_valid;
    logic [WAYS*AR_W-1:0]   rt_ar_idx;
    logic [WAYS*PR_W-1:0]   rt_t_idx;
    logic [WAYS*PR_W-1:0]   rt_told_idx;
    logic [WAYS-1:0]        rt_mispredict;
    logic                   br_recover_enable;
    logic [N_ARCH*PR_W-1:0] recovery_map;
    logic [WAYS-1:0]        fl_retire_valid;
    logic [WAYS*PR_W-1:0]   fl_retire_told;
    logic                   told_mismatch;
    logic [31:0]            retire_count;

    arch_maptable dut (
        .clock(clock), .reset(reset), .rt_valid(rt_valid), .rt_ar_idx(rt_ar_idx),
        .rt_t_idx(rt_t_idx), .rt_told_idx(rt_told_idx), .rt_mispredict(rt_mispredict),
        .br_recover_enable(br_recover_enable), .recovery_map(recovery_map),
        .fl_retire_valid(fl_retire_valid), .fl_retire_told(fl_retire_told),
        .told_mismatch(told_mismatch), .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] valid, misp;
        int ar0, t0, told0, ar1, t1, told1;
        logic br;
        logic [1:0] flv;
        int ftold0, ftold1, chk_ar, chk_map, cnt, mm;
    } vec_t;

    vec_t vecs [10];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rmap(input int a);
        return 32'(recovery_map[a*PR_W +: PR_W]);
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] m, input int a0, input int t0,
                         input int o0, input int a1, input int t1, input int o1);
        rt_valid      = v;
        rt_mispredict = m;
        rt_ar_idx     = {AR_W'(a1), AR_W'(a0)};
        rt_t_idx      = {PR_W'(t1), PR_W'(t0)};
        rt_told_idx   = {PR_W'(o1), PR_W'(o0)};
    endtask

    initial begin
        //          valid  misp   ar0 t0 told0 ar1 t1 told1  br    flv   ft0 ft1 ar  map cnt mm
        vecs[0] = '{2'b00, 2'b00, 0,  0,  0,   0,  0,  0,   1'b0, 2'b00, 0,  0, 31, 31, 0,  0};
        vecs[1] = '{2'b01, 2'b00, 3,  40, 3,   0,  0,  0,   1'b0, 2'b01, 3,  0, 3,  40, 1,  0};
        vecs[2] = '{2'b11, 2'b00, 5,  41, 5,   5,  42, 41,  1'b0, 2'b11, 5, 41, 5,  42, 3,  0};
        vecs[3] = '{2'b11, 2'b01, 7,  50, 7,   8,  51, 8,   1'b1, 2'b01, 7,  0, 7,  50, 4,  0};
        vecs[4] = '{2'b00, 2'b00, 0,  0,  0,   0,  0,  0,   1'b0, 2'b00, 0,  0, 8,  8,  4,  0};
        vecs[5] = '{2'b11, 2'b10, 10, 52, 10,  11, 53, 11,  1'b1, 2'b11, 10, 11, 11, 53, 6, 0};
        vecs[6] = '{2'b10, 2'b00, 13, 55, 13,  12, 54, 12,  1'b0, 2'b10, 0, 12, 13, 13, 7,  0};
        vecs[7] = '{2'b10, 2'b01, 15, 57, 15,  14, 56, 14,  1'b0, 2'b10, 0, 14, 14, 56, 8,  0};
        vecs[8] = '{2'b11, 2'b00, 0,  60, 0,   9,  61, 33,  1'b0, 2'b10, 0, 33, 0,  0,  10, 1};
        vecs[9] = '{2'b00, 2'b00, 0,  0,  0,   0,  0,  0,   1'b0, 2'b00, 0,  0, 9,  61, 10, 1};

        reset = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        for (int a = 0; a < N_ARCH; a++) chk($sformatf("reset_map[%0d]", a), rmap(a), 32'(a));
        chk("reset_fl_valid", 32'(fl_retire_valid), 0);
        chk("reset_count", retire_count, 0);
        chk("reset_mismatch", 32'(told_mismatch), 0);

        foreach (vecs[n]) begin
            @(negedge clock);
            drive(vecs[n].valid, vecs[n].misp, vecs[n].ar0, vecs[n].t0, vecs[n].told0,
                  vecs[n].ar1, vecs[n].t1, vecs[n].told1);
            #1;
            chk($sformatf("v%0d_br", n), 32'(br_recover_enable), 32'(vecs[n].br));
            chk($sformatf("v%0d_flv", n), 32'(fl_retire_valid), 32'(vecs[n].flv));
            chk($sformatf("v%0d_ftold0", n), 32'(fl_retire_told[0 +: PR_W]), 32'(vecs[n].ftold0));
            chk($sformatf("v%0d_ftold1", n), 32'(fl_retire_told[PR_W +: PR_W]), 32'(vecs[n].ftold1));
            chk($sformatf("v%0d_rmap[%0d]", n, vecs[n].chk_ar), rmap(vecs[n].chk_ar),
                32'(vecs[n].chk_map));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_count", n), retire_count, 32'(vecs[n].cnt));
            chk($sformatf("v%0d_mismatch", n), 32'(told_mismatch), 32'(vecs[n].mm));
        end

        // Registered map after all commits, including squashed way 1 of vec 3.
        @(negedge clock);
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        #1;
        chk("held_map[3]", rmap(3), 40);
        chk("held_map[5]", rmap(5), 42);
        chk("held_map[7]", rmap(7), 50);
        chk("held_map[0]", rmap(0), 0);

        // Reset with two valid retires (one mispredicting) discards them.
        @(negedge clock);
        reset = 1'b1;
        drive(2'b11, 2'b01, 20, 62, 20, 21, 63, 21);
        #1;
        chk("rst_br", 32'(br_recover_enable), 0);
        chk("rst_flv", 32'(fl_retire_valid), 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_map[20]", rmap(20), 20);
        chk("rst_map[21]", rmap(21), 21);
        chk("rst_map[3]", rmap(3), 3);
        chk("rst_map[9]", rmap(9), 9);
        chk("rst_count", retire_count, 0);
        chk("rst_mismatch", 32'(told_mismatch), 0);
        @(posedge clock);
        #1;
        chk("post_rst_count", retire_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
